// File: rtl/riscv_pkg.sv
// Shared branch-predictor definitions: 2-bit counter encodings, predictor state
// and the saturating counter update used when training the PHT.
package riscv_pkg;

    localparam logic [1:0] BP_SNT = 2'b00;
    localparam logic [1:0] BP_WNT = 2'b01;
    localparam logic [1:0] BP_WT  = 2'b10;
    localparam logic [1:0] BP_ST  = 2'b11;

    typedef enum logic {
        BP_INIT = 1'b0,
        BP_RUN  = 1'b1
    } bp_state_t;

    function automatic logic [1:0] bp_sat_update(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            nxt = (cnt == BP_ST) ? BP_ST : cnt + 2'd1;
        end else begin
            nxt = (cnt == BP_SNT) ? BP_SNT : cnt - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/riscv_bp_ram.sv
// 1R1W synchronous RAM holding the PHT. The read address is registered so data
// appears the cycle after the address is presented; contents are not reset.
module riscv_bp_ram #(
    parameter int ABITS = 12,
    parameter int DBITS = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             rd_en,
    input  logic [ABITS-1:0] rd_addr,
    output logic [ABITS-1:0] rd_addr_reg,
    output logic [DBITS-1:0] rd_data,
    input  logic             we,
    input  logic [ABITS-1:0] wr_addr,
    input  logic [DBITS-1:0] wr_data
);

    logic [DBITS-1:0] mem [2**ABITS];
    logic [ABITS-1:0] rd_addr_q;

    // rd_en low (fetch stall) freezes the address, and therefore the read data
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_addr_q <= '0;
        end else if (rd_en) begin
            rd_addr_q <= rd_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data     = mem[rd_addr_q];
    assign rd_addr_reg = rd_addr_q;

endmodule

// File: rtl/riscv_bp.sv
// Gshare branch predictor: PHT of 2-bit counters indexed by {history, PC bits},
// one-cycle read latency, trained from the branch unit's resolved branches.
module riscv_bp
    import riscv_pkg::*;
#(
    parameter int XLEN              = 32,
    parameter int HAS_BPU           = 1,
    parameter int BP_GLOBAL_BITS    = 2,
    parameter int BP_LOCAL_BITS     = 10,
    parameter int BP_LOCAL_BITS_LSB = 2
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      if_stall,
    input  logic [XLEN-1:0]           if_parcel_pc,
    output logic [1:0]                bp_bp_predict,
    output logic                      bp_init_busy,
    input  logic [XLEN-1:0]           ex_pc,
    input  logic [1:0]                bu_bp_predict,
    input  logic [BP_GLOBAL_BITS-1:0] bu_bp_history,
    input  logic                      bu_bp_btaken,
    input  logic                      bu_bp_update
);

    localparam int ABITS = BP_GLOBAL_BITS + BP_LOCAL_BITS;

    generate
        if (HAS_BPU != 0) begin : g_bpu
            bp_state_t                 state;
            logic [ABITS-1:0]          init_cnt;
            logic [BP_GLOBAL_BITS-1:0] rd_history;
            logic [ABITS-1:0]          rd_idx;
            logic [ABITS-1:0]          rd_idx_q;
            logic [ABITS-1:0]          wr_idx;
            logic [ABITS-1:0]          ram_wa;
            logic [1:0]                ram_wd;
            logic [1:0]                ram_rd;
            logic [1:0]                upd_cnt;
            logic                      ram_we;
            logic                      unused_pc;

            assign unused_pc = ^{if_parcel_pc, ex_pc};

            assign rd_idx  = {rd_history, if_parcel_pc[BP_LOCAL_BITS_LSB +: BP_LOCAL_BITS]};
            assign wr_idx  = {bu_bp_history, ex_pc[BP_LOCAL_BITS_LSB +: BP_LOCAL_BITS]};
            assign upd_cnt = bp_sat_update(bu_bp_predict, bu_bp_btaken);

            // INIT sweeps every entry once, writing weakly not-taken, then hands over to RUN
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    state    <= BP_INIT;
                    init_cnt <= '0;
                end else if (state == BP_INIT) begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == '1) begin
                        state <= BP_RUN;
                    end
                end
            end

            if (BP_GLOBAL_BITS == 1) begin : g_hist1
                always_ff @(posedge clk or negedge rstn) begin
                    if (!rstn) begin
                        rd_history <= '0;
                    end else if (state == BP_RUN && bu_bp_update) begin
                        rd_history <= bu_bp_btaken;
                    end
                end
            end else begin : g_histn
                always_ff @(posedge clk or negedge rstn) begin
                    if (!rstn) begin
                        rd_history <= '0;
                    end else if (state == BP_RUN && bu_bp_update) begin
                        rd_history <= {rd_history[BP_GLOBAL_BITS-2:0], bu_bp_btaken};
                    end
                end
            end

            always_comb begin
                ram_we = 1'b0;
                ram_wa = wr_idx;
                ram_wd = upd_cnt;
                if (state == BP_INIT) begin
                    ram_we = 1'b1;
                    ram_wa = init_cnt;
                    ram_wd = BP_WNT;
                end else if (bu_bp_update) begin
                    ram_we = 1'b1;
                end
            end

            riscv_bp_ram #(
                .ABITS (ABITS),
                .DBITS (2)
            ) u_ram (
                .clk         (clk),
                .rstn        (rstn),
                .rd_en       (~if_stall),
                .rd_addr     (rd_idx),
                .rd_addr_reg (rd_idx_q),
                .rd_data     (ram_rd),
                .we          (ram_we),
                .wr_addr     (ram_wa),
                .wr_data     (ram_wd)
            );

            // A write landing on the entry being read this cycle is forwarded (write-first)
            always_comb begin
                bp_bp_predict = BP_SNT;
                if (state == BP_RUN) begin
                    bp_bp_predict = (ram_we && ram_wa == rd_idx_q) ? ram_wd : ram_rd;
                end
            end

            assign bp_init_busy = (state == BP_INIT);
        end else begin : g_nobpu
            logic unused_in;

            assign unused_in = ^{clk, rstn, if_stall, if_parcel_pc, ex_pc, bu_bp_predict,
                                 bu_bp_history, bu_bp_btaken, bu_bp_update};

            assign bp_bp_predict = BP_SNT;
            assign bp_init_busy  = 1'b0;
        end
    endgenerate

endmodule

// File: doc/riscv_bp.md
Name: riscv_bp

Overview:
- Gshare branch predictor that sits in the fetch stage, directly upstream of the branch unit.
- Indexes a pattern-history table (PHT) of 2-bit saturating counters with {global history, PC bits} and returns a prediction one cycle after the fetch PC is presented.
- The prediction travels down the pipe to ID/EX (as id_bp_predict).
- Trains the PHT from the branch unit's resolved-branch outputs (bu_bp_*).

Parameters:
- XLEN, 32, data/address width.
- HAS_BPU, 1, 0 removes the table; prediction tied to 2'b00.
- BP_GLOBAL_BITS, 2, global history length; must match the branch unit.
- BP_LOCAL_BITS, 10, number of PC bits used in the index.
- BP_LOCAL_BITS_LSB, 2, lowest PC bit used in the index (1 when RVC is supported).

Ports:
- clk, input, 1, clock.
- rstn, input, 1, asynchronous active-low reset.
- if_stall, input, 1, fetch stalled; hold the read index and the output.
- if_parcel_pc, input, XLEN, PC being fetched this cycle.
- bp_bp_predict, output, 2, counter value for the PC presented the previous cycle.
- bp_init_busy, output, 1, high while the PHT is being initialised.
- ex_pc, input, XLEN, PC of the branch resolved in EX.
- bu_bp_predict, input, 2, counter value originally predicted for that branch.
- bu_bp_history, input, BP_GLOBAL_BITS, history in effect when that branch was predicted.
- bu_bp_btaken, input, 1, resolved direction.
- bu_bp_update, input, 1, train strobe; one per resolved conditional branch.

Behaviour:
- Counter encoding:
  - 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken.
  - The fetch stage treats bp_bp_predict[1] as the taken prediction.
- Read index = {rd_history, if_parcel_pc[BP_LOCAL_BITS_LSB +: BP_LOCAL_BITS]}.
  - PHT depth is 2^(BP_GLOBAL_BITS+BP_LOCAL_BITS).
- Write index = {bu_bp_history, ex_pc[BP_LOCAL_BITS_LSB +: BP_LOCAL_BITS]}.
- rd_history is an internal register:
  - Reset value 0.
  - On bu_bp_update it shifts to {rd_history[BP_GLOBAL_BITS-2:0], bu_bp_btaken}, mirroring the branch unit's history.
  - For BP_GLOBAL_BITS=1, rd_history = bu_bp_btaken.
- Read latency is 1 cycle:
  - A PC presented in cycle N gives bp_bp_predict in cycle N+1.
  - While if_stall=1, the registered read index is held and bp_bp_predict is stable.
- Write data is a saturating update of bu_bp_predict:
  - btaken=1: 11 stays 11, otherwise +1.
  - btaken=0: 00 stays 00, otherwise -1.
  - The table is never read back for training; single write port.
- Read/write collision:
  - Condition: write index equals the registered read index in the same cycle.
  - bp_bp_predict returns the newly written value (write-first forwarding).
- State machine {INIT, RUN}:
  - Reset enters INIT; init counter = 0, bp_init_busy=1, bp_bp_predict=00.
  - INIT: writes 2'b01 to entry init_cnt each cycle and increments. bu_bp_update is ignored, and rd_history does not shift.
  - When init_cnt reaches depth-1 it writes that entry, then moves to RUN next cycle with bp_init_busy=0.
  - INIT lasts exactly 2^(BP_GLOBAL_BITS+BP_LOCAL_BITS) cycles.
  - RUN: normal read/train operation. RUN never returns to INIT except via rstn.
  - Reset asserted mid-INIT or mid-RUN aborts immediately; INIT restarts from entry 0.
- Reset values: bp_bp_predict=00, bp_init_busy=1, rd_history=0, state=INIT.
- HAS_BPU=0:
  - bp_bp_predict=00 and bp_init_busy=0 permanently.
  - No storage inferred.
- Upper PC bits and XLEN width do not affect the index; aliasing is accepted.

Decomposition:
- riscv_pkg gains:
  - the 2-bit counter constants BP_SNT, BP_WNT, BP_WT, BP_ST;
  - a bp_state_t enum {BP_INIT, BP_RUN}.
- Sub-module riscv_bp_ram:
  - 1R1W synchronous RAM, parameters ABITS and DBITS.
  - Registered read address, no reset on contents.
  - Collision forwarding is done in riscv_bp, not in the RAM.

Test Plan:
- Reset, defaults (GLOBAL=2, LOCAL=10): bp_init_busy high for exactly 4096 cycles, bp_bp_predict=00 throughout. Then every PC reads 01.
- After init, pulse bu_bp_update with ex_pc=0x200, history=00, predict=01, btaken=1. Present if_parcel_pc=0x200 with rd_history=01 → index differs, reads 01. Drive history so the index matches → reads 10.
- Saturation, same entry:
  - three taken updates from 01 → 10, 11, 11;
  - then four not-taken updates from 11 → 10, 01, 00, 00.
- Collision: update index equal to the registered read index in the same cycle, writing 10 → bp_bp_predict=10 that cycle.
- if_stall=1 for 3 cycles while if_parcel_pc changes → bp_bp_predict unchanged. First read after the stall releases uses the new PC.
- rstn pulsed 100 cycles into RUN with trained entries → INIT restarts, full sweep, all entries read 01 again. HAS_BPU=0 build → output 00 always, busy 0.
